// File: rtl/ram_fill_drain_ctrl_if.sv
// Byte-stream, drain-stream and RAM-side signals of the fill/drain controller.
// master = controller, slave = environment (upstream, downstream and RAM).
interface ram_fill_drain_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              start;
  logic              clr;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_addr;
  logic              full;
  logic              done;
  logic [DW+AW-1:0]  sum;
  logic [DW-1:0]     max;

  modport master (
    input  in_valid, in_data, start, clr, ram_rdata, out_ready,
    output in_ready, ram_we, ram_addr, ram_wdata, out_valid, out_data,
           out_addr, full, done, sum, max
  );

  modport slave (
    output in_valid, in_data, start, clr, ram_rdata, out_ready,
    input  in_ready, ram_we, ram_addr, ram_wdata, out_valid, out_data,
           out_addr, full, done, sum, max
  );
endinterface

// File: rtl/ram_fill_drain_ctrl.sv
// Fills a single-port RAM from a byte stream, then drains it out with a running sum/max.
// Latency: fill 1 byte/cycle; drain 2 cycles/byte (read, then present), 2*DEPTH cycles per pass.
// Backpressure: in_ready drops once full; out_ready low holds the drained byte and its address.
module ram_fill_drain_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_fill_drain_ctrl_if.master bus
);

  localparam int SW = DW + AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    FILL,
    FULL,
    READ,
    OUT,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [SW-1:0] sum_q, sum_nxt;
  logic [DW-1:0] max_q, max_nxt;

  logic          in_ready_c;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic          out_valid_c;
  logic          full_c;
  logic          done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      sum_q  <= '0;
      max_q  <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      sum_q  <= sum_nxt;
      max_q  <= max_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    sum_nxt     = sum_q;
    max_nxt     = max_q;
    in_ready_c  = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = wr_ptr;
    out_valid_c = 1'b0;
    full_c      = 1'b0;
    done_c      = 1'b0;

    case (state)
      FILL: begin
        in_ready_c = 1'b1;
        ram_we_c   = bus.in_valid;
        if (bus.in_valid) begin
          wr_ptr_nxt = wr_ptr + 1'b1;
          if (wr_ptr == LAST) state_nxt = FULL;
        end
      end
      FULL, DONE: begin
        full_c = 1'b1;
        done_c = (state == DONE);
        if (state == DONE) ram_addr_c = rd_ptr;
        if (bus.start) begin
          rd_ptr_nxt = '0;
          sum_nxt    = '0;
          max_nxt    = '0;
          state_nxt  = READ;
        end
      end
      READ: begin
        ram_addr_c = rd_ptr;
        state_nxt  = OUT;
      end
      OUT: begin
        // Address stays on rd_ptr so the RAM keeps re-reading the same word under backpressure.
        ram_addr_c  = rd_ptr;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          sum_nxt = sum_q + SW'(bus.ram_rdata);
          if (bus.ram_rdata > max_q) max_nxt = bus.ram_rdata;
          if (rd_ptr == LAST) begin
            state_nxt = DONE;
          end else begin
            rd_ptr_nxt = rd_ptr + 1'b1;
            state_nxt  = READ;
          end
        end
      end
      default: state_nxt = FILL;
    endcase

    // clr wins over everything; suppress handshakes so no byte is taken and then discarded.
    if (bus.clr) begin
      state_nxt   = FILL;
      wr_ptr_nxt  = '0;
      rd_ptr_nxt  = '0;
      sum_nxt     = '0;
      max_nxt     = '0;
      in_ready_c  = 1'b0;
      ram_we_c    = 1'b0;
      out_valid_c = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = bus.in_data;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = bus.ram_rdata;
  assign bus.out_addr  = rd_ptr;
  assign bus.full      = full_c;
  assign bus.done      = done_c;
  assign bus.sum       = sum_q;
  assign bus.max       = max_q;

endmodule

// File: tb/tb_ram_fill_drain_ctrl.sv
// Randomized bench for ram_fill_drain_ctrl with a behavioural 8x8 RAM and an array-based reference.
module tb_ram_fill_drain_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_fill_drain_ctrl_if #(.DW(DW), .AW(AW)) bus();

  ram_fill_drain_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Single-port RAM with registered read data.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_mem [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ref_sum();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(exp_mem[i]);
    return s;
  endfunction

  function automatic int ref_max();
    int m = 0;
    for (int i = 0; i < DEPTH; i++) if (int'(exp_mem[i]) > m) m = int'(exp_mem[i]);
    return m;
  endfunction

  // mode: 0 ramp 10..80, 1 all 255, 2 all 0, 3 alternating valid, 4 random valid; 3/4 also pulse start
  task automatic fill(input int mode);
    int cnt = 0;
    int guard = 0;
    logic [DW-1:0] d;
    while (cnt < DEPTH && guard < 200) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       d = 8'((cnt + 1) * 10);
        1:       d = 8'hff;
        2:       d = 8'h00;
        default: d = 8'($urandom);
      endcase
      bus.in_data  = d;
      bus.in_valid = (mode == 3) ? guard[0] : (mode == 4) ? 1'($urandom % 2) : 1'b1;
      bus.start    = (mode >= 3) ? ($urandom % 3 == 0) : 1'b0;
      #1;
      check_eq("fill_in_ready", bus.in_ready, 1);
      check_eq("fill_flags", {bus.full, bus.done, bus.out_valid}, 0);
      check_eq("fill_we", bus.ram_we, bus.in_valid);
      if (bus.in_valid) begin
        check_eq("fill_addr", bus.ram_addr, cnt);
        check_eq("fill_wdata", bus.ram_wdata, d);
        exp_mem[cnt] = d;
        cnt++;
      end
    end
    if (cnt < DEPTH) check_eq("fill_timeout", cnt, DEPTH);
    // Idle in FULL with an extra valid byte offered: nothing may be written.
    repeat (2) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.start    = 1'b0;
      #1;
      check_eq("full_flags", {bus.full, bus.done, bus.in_ready, bus.ram_we, bus.out_valid}, 5'b10000);
    end
    bus.in_valid = 1'b0;
  endtask

  // mode: 0 always ready, 1 random ready, 2 stall 3 cycles at address 2; abort_at>0 resets mid-pass
  task automatic drain(input int mode, input int abort_at);
    int idx = 0;
    int k = 0;
    int stall = 0;
    int msum = 0;
    int mmax = 0;
    logic rdy;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check_eq("start_out_valid", bus.out_valid, 0);
    while (idx < DEPTH && k < 400) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (abort_at > 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq("abort_flags", {bus.out_valid, bus.done, bus.full, bus.in_ready}, 4'b0001);
        check_eq("abort_sum", bus.sum, 0);
        check_eq("abort_max", bus.max, 0);
        check_eq("abort_addr", bus.ram_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom % 2);
        default: rdy = !(idx == 2 && stall < 3);
      endcase
      bus.out_ready = rdy;
      #1;
      check_eq("drain_flags", {bus.done, bus.full, bus.in_ready, bus.ram_we}, 0);
      if (mode == 0) check_eq("drain_valid_cadence", bus.out_valid, k % 2);
      if (bus.out_valid) begin
        check_eq("drain_addr", bus.out_addr, idx);
        check_eq("drain_data", bus.out_data, exp_mem[idx]);
        check_eq("drain_sum", bus.sum, msum);
        check_eq("drain_max", bus.max, mmax);
        if (rdy) begin
          msum += int'(exp_mem[idx]);
          if (int'(exp_mem[idx]) > mmax) mmax = int'(exp_mem[idx]);
          idx++;
        end else begin
          stall++;
        end
      end
      k++;
    end
    if (idx < DEPTH) check_eq("drain_timeout", idx, DEPTH);
    if (mode == 0) check_eq("drain_cycles", k, 2 * DEPTH);
    repeat (2) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom % 2);
      #1;
      check_eq("done_flags", {bus.done, bus.full, bus.out_valid, bus.in_ready, bus.ram_we}, 5'b11000);
      check_eq("done_sum", bus.sum, ref_sum());
      check_eq("done_max", bus.max, ref_max());
    end
  endtask

  task automatic clear();
    @(negedge clk);
    bus.clr   = 1'b1;
    bus.start = 1'($urandom % 2);
    @(negedge clk);
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    #1;
    check_eq("clr_flags", {bus.in_ready, bus.full, bus.done, bus.out_valid}, 4'b1000);
    check_eq("clr_sum", bus.sum, 0);
    check_eq("clr_max", bus.max, 0);
    check_eq("clr_addr", bus.ram_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.start     = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check_eq("rst_flags", {bus.in_ready, bus.ram_we, bus.out_valid, bus.full, bus.done}, 5'b10000);
    check_eq("rst_ram_addr", bus.ram_addr, 0);
    check_eq("rst_out_addr", bus.out_addr, 0);
    check_eq("rst_sum", bus.sum, 0);
    check_eq("rst_max", bus.max, 0);
    @(negedge clk);
    rst = 1'b0;

    fill(0);
    drain(0, 0);
    check_eq("ramp_sum", bus.sum, 360);
    check_eq("ramp_max", bus.max, 80);
    drain(2, 0);
    check_eq("ramp_stall_sum", bus.sum, 360);

    clear();
    fill(1);
    drain(0, 0);
    check_eq("ff_sum", bus.sum, 2040);
    check_eq("ff_max", bus.max, 255);

    clear();
    fill(2);
    drain(1, 0);
    check_eq("zero_sum", bus.sum, 0);
    check_eq("zero_max", bus.max, 0);

    clear();
    fill(3);
    drain(1, 0);

    clear();
    fill(4);
    drain(1, 3);
    fill(4);
    drain(1, 0);

    for (int p = 0; p < 6; p++) begin
      clear();
      fill(4);
      drain(p % 3, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
